// File: rtl/counter_pkg.sv
// Shared definitions for the 4-bit mode counter and its companions:
// mode encodings, the count type and the reference step functions.
package counter_pkg;

  typedef logic [3:0] q_t;

  typedef enum logic [1:0] {
    MODE_UP3  = 2'b00,
    MODE_DN1  = 2'b01,
    MODE_UP1  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  function automatic q_t next_q(input q_t q, input mode_e mode, input q_t d);
    case (mode)
      MODE_UP3: next_q = q + 4'd3;
      MODE_DN1: next_q = q - 4'd1;
      MODE_UP1: next_q = q + 4'd1;
      default:  next_q = d;
    endcase
  endfunction

  // Wrap flag of a step taken from q: set when the modulo-16 result folded over.
  function automatic logic exp_rco(input q_t q, input mode_e mode);
    case (mode)
      MODE_UP3: exp_rco = (q >= 4'd13);
      MODE_DN1: exp_rco = (q == 4'd0);
      MODE_UP1: exp_rco = (q == 4'd15);
      default:  exp_rco = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/count_step_model.sv
// Combinational reference for one counter step: what Q, rco and load should
// show after a step governed by the sampled mode, data and previous count.
module count_step_model
  import counter_pkg::*;
(
  input  q_t    q_prev,
  input  mode_e mode_p,
  input  q_t    D_p,
  output q_t    exp_q,
  output logic  exp_rco,
  output logic  exp_load
);

  assign exp_q    = next_q(q_prev, mode_p, D_p);
  assign exp_rco  = counter_pkg::exp_rco(q_prev, mode_p);
  assign exp_load = (mode_p == MODE_LOAD);

endmodule

// File: rtl/count_extender.sv
// Extends the 4-bit mode counter to HI_W+4 bits, checks each counter step
// against the reference model and hands out snapshots over valid/ready.
module count_extender
  import counter_pkg::*;
#(
  parameter int HI_W   = 8,
  parameter int ERRC_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [3:0]        D,
  input  logic [3:0]        Q,
  input  logic              rco,
  input  logic              load,
  input  logic              snap_req,
  input  logic              snap_ready,
  output logic              snap_valid,
  output logic [HI_W+3:0]   snap_data,
  input  logic              clr_sticky,
  output logic              ovf,
  output logic              step_err,
  output logic [ERRC_W-1:0] err_cnt,
  output logic              snap_drop
);

  mode_e           mode_p;
  logic            en_p;
  q_t              D_p;
  q_t              q_prev;
  logic            armed;
  logic [HI_W-1:0] hi;
  logic [HI_W-1:0] hi_next;
  logic            hi_wrap;
  q_t              exp_q;
  logic            exp_rco_w;
  logic            exp_load_w;
  logic            mismatch;
  logic            err_evt;
  logic            capture;
  logic            drop_evt;

  function automatic logic [ERRC_W-1:0] sat_inc(input logic [ERRC_W-1:0] c);
    sat_inc = (&c) ? c : c + ERRC_W'(1);
  endfunction

  count_step_model u_step_model (
    .q_prev   (q_prev),
    .mode_p   (mode_p),
    .D_p      (D_p),
    .exp_q    (exp_q),
    .exp_rco  (exp_rco_w),
    .exp_load (exp_load_w)
  );

  always_comb begin
    hi_next = hi;
    hi_wrap = 1'b0;
    if (load) begin
      hi_next = '0;
    end else if (rco && en_p) begin
      case (mode_p)
        MODE_UP3, MODE_UP1: begin
          hi_next = hi + HI_W'(1);
          hi_wrap = &hi;
        end
        MODE_DN1: begin
          hi_next = hi - HI_W'(1);
          hi_wrap = ~|hi;
        end
        default: ;
      endcase
    end
  end

  assign mismatch = (Q != exp_q) || (rco != exp_rco_w) || (load != exp_load_w);
  // A wrap flag under a load step never moves hi, so it is always an error.
  assign err_evt  = (armed && en_p && mismatch) || (rco && (mode_p == MODE_LOAD));
  assign capture  = snap_req && (!snap_valid || snap_ready);
  assign drop_evt = snap_req && snap_valid && !snap_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_p     <= MODE_UP3;
      en_p       <= 1'b0;
      D_p        <= '0;
      q_prev     <= '0;
      armed      <= 1'b0;
      hi         <= '0;
      snap_valid <= 1'b0;
      snap_data  <= '0;
      ovf        <= 1'b0;
      step_err   <= 1'b0;
      err_cnt    <= '0;
      snap_drop  <= 1'b0;
    end else begin
      mode_p <= mode_e'(mode);
      en_p   <= enable;
      D_p    <= D;
      q_prev <= Q;
      armed  <= 1'b1;
      hi     <= hi_next;

      if (capture) begin
        snap_data  <= {hi_next, Q};
        snap_valid <= 1'b1;
      end else if (snap_ready) begin
        snap_valid <= 1'b0;
      end

      // Clear wins: an event landing in the clearing cycle is dropped.
      if (clr_sticky) begin
        ovf       <= 1'b0;
        step_err  <= 1'b0;
        err_cnt   <= '0;
        snap_drop <= 1'b0;
      end else begin
        if (hi_wrap)  ovf <= 1'b1;
        if (err_evt) begin
          step_err <= 1'b1;
          err_cnt  <= sat_inc(err_cnt);
        end
        if (drop_evt) snap_drop <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_count_extender.sv
// Bench for count_extender: emulates the 4-bit counter, keeps an arithmetic
// reference of the extended count, flags and snapshot port, and compares.
module tb_count_extender;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [1:0]  mode;
  logic [3:0]  D;
  logic [3:0]  Q;
  logic        rco;
  logic        load;
  logic        snap_req;
  logic        snap_ready;
  logic        snap_valid;
  logic [11:0] snap_data;
  logic        clr_sticky;
  logic        ovf;
  logic        step_err;
  logic [3:0]  err_cnt;
  logic        snap_drop;

  count_extender #(.HI_W(8), .ERRC_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .mode       (mode),
    .D          (D),
    .Q          (Q),
    .rco        (rco),
    .load       (load),
    .snap_req   (snap_req),
    .snap_ready (snap_ready),
    .snap_valid (snap_valid),
    .snap_data  (snap_data),
    .clr_sticky (clr_sticky),
    .ovf        (ovf),
    .step_err   (step_err),
    .err_cnt    (err_cnt),
    .snap_drop  (snap_drop)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference state
  int m_hi, m_data, m_errc;
  bit m_valid, m_ovf, m_serr, m_drop, m_armed;
  int pc_mode, pc_en, pc_d, pc_q;

  typedef struct {
    logic [1:0]  mode;
    logic        en;
    logic [3:0]  d;
    logic        req;
    logic        rdy;
    logic        exp_valid;
    logic [11:0] exp_data;
    logic        exp_err;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_cmp++;
    if (act !== 32'(exp)) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_hi = 0; m_data = 0; m_errc = 0;
    m_valid = 0; m_ovf = 0; m_serr = 0; m_drop = 0; m_armed = 0;
    pc_mode = 0; pc_en = 0; pc_d = 0; pc_q = 0;
  endtask

  task automatic check_all();
    chk("snap_valid", {31'd0, snap_valid}, int'(m_valid));
    chk("snap_data", {20'd0, snap_data}, m_data);
    chk("ovf", {31'd0, ovf}, int'(m_ovf));
    chk("step_err", {31'd0, step_err}, int'(m_serr));
    chk("err_cnt", {28'd0, err_cnt}, m_errc);
    chk("snap_drop", {31'd0, snap_drop}, int'(m_drop));
  endtask

  // One clock: update the reference from the pre-edge view, step the
  // emulated counter after the edge, then compare every output.
  task automatic tick();
    int h, s, eq;
    bit er, el, e_ovf, e_err, e_drop, c_en;
    int c_mode, c_d;
    h = m_hi; e_ovf = 0; e_err = 0; e_drop = 0;
    if (load) h = 0;
    else if (rco && pc_en != 0 && pc_mode != 3) begin
      h = m_hi + ((pc_mode == 1) ? -1 : 1);
      if (h < 0 || h > 255) e_ovf = 1;
      h = (h + 256) % 256;
    end
    if (m_armed && pc_en != 0) begin
      case (pc_mode)
        0: s = pc_q + 3;
        1: s = pc_q - 1;
        2: s = pc_q + 1;
        default: s = pc_d;
      endcase
      eq = (s + 16) % 16;
      er = (pc_mode != 3) && (s < 0 || s > 15);
      el = (pc_mode == 3);
      if (int'(Q) != eq || rco != er || load != el) e_err = 1;
    end
    if (rco && pc_mode == 3) e_err = 1;
    if (snap_req) begin
      if (m_valid && !snap_ready) e_drop = 1;
      else begin
        m_data = h * 16 + int'(Q);
        m_valid = 1;
      end
    end else if (snap_ready) m_valid = 0;
    if (clr_sticky) begin
      m_ovf = 0; m_serr = 0; m_drop = 0; m_errc = 0;
    end else begin
      if (e_ovf) m_ovf = 1;
      if (e_err) begin
        m_serr = 1;
        if (m_errc < 15) m_errc++;
      end
      if (e_drop) m_drop = 1;
    end
    m_hi = h;
    pc_mode = int'(mode); pc_en = int'(enable); pc_d = int'(D); pc_q = int'(Q);
    m_armed = 1;
    c_en = enable; c_mode = int'(mode); c_d = int'(D);

    @(posedge clk);
    #1;
    if (c_en) begin
      if (c_mode == 3) begin
        Q = 4'(c_d); load = 1'b1; rco = 1'b0;
      end else begin
        case (c_mode)
          0: s = int'(Q) + 3;
          1: s = int'(Q) - 1;
          default: s = int'(Q) + 1;
        endcase
        rco = (s < 0 || s > 15);
        Q = 4'((s + 16) % 16);
        load = 1'b0;
      end
    end else begin
      rco = 1'b0; load = 1'b0;
    end
    check_all();
  endtask

  task automatic set_ctl(input logic en, input logic [1:0] md, input logic [3:0] d);
    enable = en; mode = md; D = d;
  endtask

  initial begin
    logic [11:0] held;
    int guard;

    tbl[0] = '{mode: 2'b11, en: 1'b1, d: 4'd14, req: 1'b0, rdy: 1'b0, exp_valid: 1'b0, exp_data: 12'h000, exp_err: 1'b0};
    tbl[1] = '{mode: 2'b10, en: 1'b1, d: 4'd0,  req: 1'b0, rdy: 1'b0, exp_valid: 1'b0, exp_data: 12'h000, exp_err: 1'b0};
    tbl[2] = '{mode: 2'b10, en: 1'b1, d: 4'd0,  req: 1'b0, rdy: 1'b0, exp_valid: 1'b0, exp_data: 12'h000, exp_err: 1'b0};
    tbl[3] = '{mode: 2'b10, en: 1'b1, d: 4'd0,  req: 1'b0, rdy: 1'b0, exp_valid: 1'b0, exp_data: 12'h000, exp_err: 1'b0};
    tbl[4] = '{mode: 2'b10, en: 1'b1, d: 4'd0,  req: 1'b1, rdy: 1'b0, exp_valid: 1'b1, exp_data: 12'h011, exp_err: 1'b0};
    tbl[5] = '{mode: 2'b10, en: 1'b1, d: 4'd0,  req: 1'b0, rdy: 1'b1, exp_valid: 1'b0, exp_data: 12'h011, exp_err: 1'b0};

    reset = 1'b0;
    set_ctl(1'b0, 2'b00, 4'd0);
    Q = 4'd0; rco = 1'b0; load = 1'b0;
    snap_req = 1'b0; snap_ready = 1'b0; clr_sticky = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset = 1'b1;

    // up by 1 across a wrap, then snapshot and drain
    for (int i = 0; i < 6; i++) begin
      set_ctl(tbl[i].en, tbl[i].mode, tbl[i].d);
      snap_req = tbl[i].req; snap_ready = tbl[i].rdy;
      tick();
      chk($sformatf("tbl%0d_valid", i), {31'd0, snap_valid}, int'(tbl[i].exp_valid));
      chk($sformatf("tbl%0d_data", i), {20'd0, snap_data}, int'(tbl[i].exp_data));
      chk($sformatf("tbl%0d_err", i), {31'd0, step_err}, int'(tbl[i].exp_err));
    end
    snap_req = 1'b0; snap_ready = 1'b0;

    // down-count underflow from Q=0, hi=0
    set_ctl(1'b1, 2'b11, 4'd0); tick();
    set_ctl(1'b1, 2'b01, 4'd0); tick();
    snap_req = 1'b1; tick(); snap_req = 1'b0;
    chk("underflow_ovf", {31'd0, ovf}, 1);
    chk("underflow_snap", {20'd0, snap_data}, 12'hFFF);
    set_ctl(1'b0, 2'b01, 4'd0);
    clr_sticky = 1'b1; snap_ready = 1'b1; tick();
    clr_sticky = 1'b0; snap_ready = 1'b0;
    chk("ovf_cleared", {31'd0, ovf}, 0);

    // up by 3 from Q=12 with one wrap
    set_ctl(1'b1, 2'b11, 4'd12); tick();
    set_ctl(1'b1, 2'b00, 4'd0); tick();
    tick();
    set_ctl(1'b0, 2'b00, 4'd0);
    snap_req = 1'b1; tick(); snap_req = 1'b0;
    chk("up3_snap", {20'd0, snap_data}, 12'h012);
    chk("up3_err", {31'd0, step_err}, 0);

    // snapshot hold, dropped request, release
    snap_ready = 1'b1; tick(); snap_ready = 1'b0;
    set_ctl(1'b1, 2'b10, 4'd0);
    snap_req = 1'b1; tick(); snap_req = 1'b0;
    held = snap_data;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_valid", {31'd0, snap_valid}, 1);
      chk("hold_data", {20'd0, snap_data}, int'(held));
    end
    snap_req = 1'b1; tick(); snap_req = 1'b0;
    chk("drop_flag", {31'd0, snap_drop}, 1);
    chk("drop_data", {20'd0, snap_data}, int'(held));
    snap_ready = 1'b1; tick(); snap_ready = 1'b0;
    chk("release_valid", {31'd0, snap_valid}, 0);
    clr_sticky = 1'b1; tick(); clr_sticky = 1'b0;

    // fault injection: Q=5 where 4 is due, then 20 more faults
    set_ctl(1'b1, 2'b11, 4'd3); tick();
    set_ctl(1'b1, 2'b10, 4'd0); tick();
    Q = 4'd5;
    tick();
    chk("fault_step_err", {31'd0, step_err}, 1);
    chk("fault_err_cnt", {28'd0, err_cnt}, 1);
    for (int i = 0; i < 20; i++) begin
      Q = Q ^ 4'h8;
      tick();
    end
    chk("err_cnt_sat", {28'd0, err_cnt}, 15);
    clr_sticky = 1'b1; tick(); clr_sticky = 1'b0;
    chk("err_cnt_clr", {28'd0, err_cnt}, 0);

    // build hi = 7, hold a snapshot, then reset mid-operation
    set_ctl(1'b1, 2'b11, 4'd15); tick();
    set_ctl(1'b1, 2'b10, 4'd0);
    guard = 0;
    while (m_hi != 7 && guard < 200) begin
      tick();
      guard++;
    end
    chk("reach_hi7", guard < 200 ? 32'd1 : 32'd0, 1);
    set_ctl(1'b0, 2'b10, 4'd0); tick();
    snap_req = 1'b1; tick(); snap_req = 1'b0;
    chk("pre_reset_valid", {31'd0, snap_valid}, 1);
    chk("pre_reset_hi", {24'd0, snap_data[11:4]}, 7);
    #2 reset = 1'b0;
    #1;
    model_reset();
    Q = 4'd0; rco = 1'b0; load = 1'b0;
    check_all();
    @(posedge clk);
    #1;
    reset = 1'b1;
    set_ctl(1'b1, 2'b10, 4'd0);
    Q = 4'd9;
    repeat (4) tick();
    chk("post_reset_err", {31'd0, step_err}, 0);

    // randomized traffic with occasional faults and clears
    for (int i = 0; i < 400; i++) begin
      set_ctl(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
      snap_req   = ($urandom_range(0, 3) == 0);
      snap_ready = ($urandom_range(0, 1) == 1);
      clr_sticky = ($urandom_range(0, 15) == 0);
      tick();
      if ($urandom_range(0, 19) == 0) Q = Q ^ 4'($urandom_range(1, 15));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
